hsv_pixel_receiver: RTL and testbench
=====================================

HSV_PIXEL_RECEIVER -- requirements
Module: hsv_pixel_receiver

Interface
REQ-001 SHALL have parameter ROWS, default 16, image rows per frame (1..16).
REQ-002 SHALL have parameter COLS, default 16, image columns per frame (1..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50000, fpga_clk cycles of pi_clk inactivity before resync.
REQ-005 SHALL have port fpga_clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port pi_clk, input, 1, Raspberry Pi serial bit clock, asynchronous to fpga_clk.
REQ-008 SHALL have port data_in, input, 1, serial HSV data bit, asynchronous to fpga_clk.
REQ-009 SHALL have port pix_hsv, output, 24, FIFO head word: [7:0] hue, [15:8] saturation, [23:16] value.
REQ-010 SHALL have port pix_row, output, 4, row tag of the FIFO head word.
REQ-011 SHALL have port pix_col, output, 4, column tag of the FIFO head word.
REQ-012 SHALL have port pix_valid, output, 1, FIFO non-empty.
REQ-013 SHALL have port pix_ready, input, 1, consumer accepts the head word.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse when the last pixel of a frame is pushed.
REQ-015 SHALL have port overflow, output, 1, sticky flag: a completed word was dropped.
REQ-016 SHALL have port resync, output, 1, one-cycle pulse when the inactivity timeout fires.

Function
REQ-017 SHALL pass pi_clk and data_in through separate 2-flop synchronizers of equal depth.
REQ-018 SHALL detect a pi_clk rising edge when the previous synchronized pi_clk is 0 and the current one is 1; each edge samples exactly one bit.
REQ-019 SHALL sample the synchronized data_in in the edge-detect cycle.
REQ-020 SHALL shift LSB-first: the k-th bit of a word (k=0..23) lands in hsv bit k.
REQ-021 SHALL use FSM states IDLE (bit count 0) and RECV (1..23 bits held); the first edge moves IDLE->RECV; the 24th edge completes the word and returns to IDLE.
REQ-022 SHALL push a completed word into the FIFO in the cycle after the 24th edge, tagged with the current row/col.
REQ-023 SHALL advance col after each completed word, wrap col from COLS-1 to 0 while incrementing row, and wrap row from ROWS-1 to 0.
REQ-024 SHALL assert frame_done for exactly one cycle, coincident with the push of the (ROWS-1, COLS-1) word.
REQ-025 SHALL drop a completed word when the FIFO is full and no pop occurs that cycle, set overflow, and still advance row/col.
REQ-026 SHALL accept a push into a full FIFO when a pop (pix_valid && pix_ready) occurs in the same cycle; the count stays unchanged.
REQ-027 SHALL pop the head on pix_valid && pix_ready; pix_hsv, pix_row and pix_col hold stable while pix_valid=1 and pix_ready=0.
REQ-028 SHALL assert pix_valid the cycle after a push into an empty FIFO; bit-to-output latency is 2 sync + 1 edge + 1 push cycles after the final pi_clk rise.
REQ-029 SHALL count fpga_clk cycles since the last detected edge, saturating, while in RECV or while row/col is non-zero.
REQ-030 SHALL, when the count reaches TIMEOUT_CYCLES, discard the partial word, clear row/col, enter IDLE, and pulse resync for one cycle; FIFO contents are kept.
REQ-031 SHALL reset the inactivity count on every detected edge; the timeout never fires in IDLE at frame position (0,0).
REQ-032 SHALL give an edge precedence over a timeout that becomes due in the same cycle.

Reset
REQ-033 SHALL, on rst high, asynchronously clear the synchronizers, shift register, bit count, row/col, timeout count and FIFO pointers, and set the FSM to IDLE.
REQ-034 SHALL drive outputs while in reset as: pix_valid=0, pix_hsv=0, pix_row=0, pix_col=0, frame_done=0, overflow=0, resync=0.
REQ-035 SHALL, on reset during RECV, lose the partial word, with the first edge after release starting a new word at bit 0.

Verification
REQ-036 SHALL cover: serial 24'hC8_B4_3C LSB-first with pix_ready=1 -> pix_valid, pix_hsv=24'hC8B43C, row=0, col=0.
REQ-037 SHALL cover: 256 words with ROWS=COLS=16 and pix_ready=1 -> the last word is tagged (15,15), frame_done pulses once, and the next word is tagged (0,0).
REQ-038 SHALL cover: pix_ready=0 with 5 words sent (FIFO_DEPTH=4) -> 4 words held, overflow=1, the 5th dropped, and the next word tagged col=5.
REQ-039 SHALL cover: 10 bits sent then TIMEOUT_CYCLES idle -> one resync pulse, then a full word is received intact at (0,0).
REQ-040 SHALL cover: rst pulsed after 12 bits -> all outputs 0, and the next 24 bits form a correct word at (0,0).
REQ-041 SHALL cover: FIFO full, with the 24th edge coinciding with a pop -> no overflow, count stays 4, order preserved.

Source files
------------

// File: rtl/hsv_pixel_receiver.sv
// Serial HSV pixel receiver: synchronizes the Pi bit clock and data, assembles
// 24-bit LSB-first words, tags them with row/col and queues them in a small FIFO.
module hsv_pixel_receiver #(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        fpga_clk,
    input  logic        rst,
    input  logic        pi_clk,
    input  logic        data_in,
    output logic [23:0] pix_hsv,
    output logic [3:0]  pix_row,
    output logic [3:0]  pix_col,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        overflow,
    output logic        resync
);

    // state | meaning
    // IDLE  | no bits of the current word held (bit count 0)
    // RECV  | 1..23 bits of the current word held in the shift register

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state, state_nxt;
    logic          pi_s1, pi_s2, pi_prev;
    logic          d_s1, d_s2;
    logic [23:0]   sr;
    logic [4:0]    bit_cnt;
    logic          push_pend;
    logic [TW-1:0] tmr;
    logic [3:0]    row, col;
    logic [AW:0]   wptr, rptr;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [31:0]   head;

    logic pi_rise, last_bit, tmr_active, timeout;
    logic fifo_full, pop, push_ok;

    assign pi_rise    = pi_s2 & ~pi_prev;
    assign last_bit   = pi_rise && (bit_cnt == 5'd23);
    assign tmr_active = (state == RECV) || (row != 4'd0) || (col != 4'd0);
    // an edge in the same cycle always wins over a due timeout
    assign timeout    = tmr_active && !pi_rise && (tmr == '0);

    assign fifo_full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pix_valid = (wptr != rptr);
    assign pop       = pix_valid && pix_ready;
    assign push_ok   = push_pend && (!fifo_full || pop);

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pi_rise) state_nxt = RECV;
            RECV: if (last_bit || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            pi_s1     <= 1'b0;
            pi_s2     <= 1'b0;
            pi_prev   <= 1'b0;
            d_s1      <= 1'b0;
            d_s2      <= 1'b0;
            sr        <= '0;
            bit_cnt   <= '0;
            push_pend <= 1'b0;
            tmr       <= TMR_LOAD;
        end else begin
            pi_s1     <= pi_clk;
            pi_s2     <= pi_s1;
            pi_prev   <= pi_s2;
            d_s1      <= data_in;
            d_s2      <= d_s1;
            push_pend <= last_bit;
            if (pi_rise) begin
                sr      <= {d_s2, sr[23:1]};
                bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
            end else if (timeout) begin
                sr      <= '0;
                bit_cnt <= '0;
            end
            if (pi_rise || !tmr_active) begin
                tmr <= TMR_LOAD;
            end else if (tmr != '0) begin
                tmr <= tmr - TW'(1);
            end
        end
    end

    // frame position advances even when the word is dropped
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            overflow <= 1'b0;
        end else begin
            if (timeout) begin
                row <= '0;
                col <= '0;
            end else if (push_pend) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
            if (push_pend && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= {row, col, sr};
        end
    end

    assign head       = mem[rptr[AW-1:0]];
    assign pix_hsv    = pix_valid ? head[23:0]  : 24'd0;
    assign pix_col    = pix_valid ? head[27:24] : 4'd0;
    assign pix_row    = pix_valid ? head[31:28] : 4'd0;
    assign frame_done = push_pend && (row == ROW_LAST) && (col == COL_LAST);
    assign resync     = timeout;

endmodule

// File: tb/tb_hsv_pixel_receiver.sv
// Directed bench for hsv_pixel_receiver: vector table of words plus sequences
// for frame wrap, overflow, timeout, mid-word reset and full-FIFO push/pop.
module tb_hsv_pixel_receiver;

    localparam int T_OUT = 100;

    logic        fpga_clk = 1'b0;
    logic        rst = 1'b1;
    logic        pi_clk = 1'b0;
    logic        data_in = 1'b0;
    logic        pix_ready = 1'b0;
    logic [23:0] pix_hsv;
    logic [3:0]  pix_row, pix_col;
    logic        pix_valid, frame_done, overflow, resync;

    int n_checks = 0;
    int n_fail = 0;
    int fd_count = 0;
    int rs_count = 0;
    logic [31:0] popq[$];

    typedef struct {
        logic [23:0] hsv;
        logic [3:0]  row;
        logic [3:0]  col;
    } vec_t;
    vec_t vecs[6];

    hsv_pixel_receiver #(
        .ROWS(16), .COLS(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .fpga_clk(fpga_clk), .rst(rst), .pi_clk(pi_clk), .data_in(data_in),
        .pix_hsv(pix_hsv), .pix_row(pix_row), .pix_col(pix_col),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .overflow(overflow), .resync(resync)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(negedge fpga_clk) begin
        if (pix_valid && pix_ready) popq.push_back({pix_row, pix_col, pix_hsv});
        if (frame_done) fd_count++;
        if (resync) rs_count++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            #2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pop(input string name, input logic [23:0] hsv,
                              input logic [3:0] row, input logic [3:0] col);
        if (popq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no word expected %0h", name, {row, col, hsv});
        end else begin
            check(name, popq.pop_front(), {row, col, hsv});
        end
    endtask

    task automatic send_bit(input logic b);
        pi_clk  = 1'b0;
        data_in = b;
        tick(3);
        pi_clk  = 1'b1;
        tick(3);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int k = 0; k < n; k++) send_bit(w[k]);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 24);
    endtask

    task automatic do_reset();
        pi_clk  = 1'b0;
        data_in = 1'b0;
        rst     = 1'b1;
        tick(3);
        rst     = 1'b0;
        tick(2);
        popq.delete();
        fd_count = 0;
        rs_count = 0;
    endtask

    function automatic logic [23:0] frame_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A};
    endfunction

    initial begin
        logic [23:0] w4;

        vecs[0] = '{24'hC8B43C, 4'd0, 4'd0};
        vecs[1] = '{24'h000000, 4'd0, 4'd1};
        vecs[2] = '{24'hFFFFFF, 4'd0, 4'd2};
        vecs[3] = '{24'hA55A01, 4'd0, 4'd3};
        vecs[4] = '{24'h123456, 4'd0, 4'd4};
        vecs[5] = '{24'h800001, 4'd0, 4'd5};

        // reset values
        tick(2);
        check("reset_data", {pix_row, pix_col, pix_hsv}, 32'd0);
        check("reset_flags", 32'({pix_valid, frame_done, overflow, resync}), 32'd0);
        do_reset();

        // vector table, consumer always ready
        pix_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].hsv);
            tick(6);
            expect_pop($sformatf("vec%0d", i), vecs[i].hsv, vecs[i].row, vecs[i].col);
        end
        check("vec_no_frame_done", 32'(fd_count), 32'd0);

        // full frame with wrap
        do_reset();
        pix_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("frame_done_early", 32'(fd_count), 32'd0);
            send_word(frame_word(i));
            tick(6);
            expect_pop($sformatf("frame%0d", i), frame_word(i), 4'(i / 16), 4'(i % 16));
        end
        check("frame_done_once", 32'(fd_count), 32'd1);
        send_word(24'h13579B);
        tick(6);
        expect_pop("frame_wrap", 24'h13579B, 4'd0, 4'd0);
        check("frame_done_after_wrap", 32'(fd_count), 32'd1);

        // overflow with consumer stalled
        do_reset();
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(24'h100000 + 24'(i));
        tick(6);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        check("ovf_head4", {pix_row, pix_col, pix_hsv}, {8'h00, 24'h100000});
        send_word(24'h100004);
        tick(6);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head5", {pix_row, pix_col, pix_hsv}, {8'h00, 24'h100000});
        pix_ready = 1'b1;
        tick(8);
        for (int i = 0; i < 4; i++)
            expect_pop($sformatf("ovf_drain%0d", i), 24'h100000 + 24'(i), 4'd0, 4'(i));
        check("ovf_dropped", 32'(popq.size()), 32'd0);
        check("ovf_empty", 32'(pix_valid), 32'd0);
        send_word(24'h2468AC);
        tick(6);
        expect_pop("ovf_next_col5", 24'h2468AC, 4'd0, 4'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // inactivity timeout mid-word
        do_reset();
        pix_ready = 1'b1;
        send_bits(24'hFFFFFF, 10);
        tick(T_OUT - 10);
        check("timeout_not_early", 32'(rs_count), 32'd0);
        tick(30);
        check("timeout_fired", 32'(rs_count), 32'd1);
        tick(250);
        check("timeout_once", 32'(rs_count), 32'd1);
        check("timeout_no_word", 32'(popq.size()), 32'd0);
        send_word(24'h5A3C96);
        tick(6);
        expect_pop("timeout_next_word", 24'h5A3C96, 4'd0, 4'd0);

        // reset in the middle of a word
        do_reset();
        pix_ready = 1'b0;
        send_word(24'hABCDEF);
        tick(6);
        check("rstmid_valid_before", 32'(pix_valid), 32'd1);
        send_bits(24'hFFFFFF, 12);
        pi_clk = 1'b0;
        rst = 1'b1;
        tick(1);
        check("rstmid_data", {pix_row, pix_col, pix_hsv}, 32'd0);
        check("rstmid_flags", 32'({pix_valid, frame_done, overflow, resync}), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        popq.delete();
        pix_ready = 1'b1;
        send_word(24'hC0FFEE);
        tick(6);
        expect_pop("rstmid_next_word", 24'hC0FFEE, 4'd0, 4'd0);
        check("rstmid_only_one", 32'(popq.size()), 32'd0);

        // full FIFO: push lands in the same cycle as a pop
        do_reset();
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(24'h300000 + 24'(i));
        w4 = 24'h300004;
        send_bits(w4, 23);
        pi_clk  = 1'b0;
        data_in = w4[23];
        tick(3);
        pi_clk  = 1'b1;
        tick(3);
        pix_ready = 1'b1;
        tick(1);
        pix_ready = 1'b0;
        tick(3);
        check("simul_no_overflow", 32'(overflow), 32'd0);
        check("simul_one_popped", 32'(popq.size()), 32'd1);
        check("simul_head", {pix_row, pix_col, pix_hsv}, {8'h01, 24'h300001});
        pix_ready = 1'b1;
        tick(8);
        for (int i = 0; i < 5; i++)
            expect_pop($sformatf("simul_order%0d", i), 24'h300000 + 24'(i), 4'd0, 4'(i));
        check("simul_drained", 32'(pix_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
